config_chain_loader: RTL and testbench
======================================

Name: config_chain_loader

Overview:
- Drives the configuration shift chain that runs through a row of tiles: connection blocks, switch boxes and CLBs.
- Accepts configuration words from a word-stream source and serializes them onto the chain's shift_in together with cen.
- After the last bit has been shifted, pulses set so every tile latches its shifted configuration.
- Captures the bits emerging from the chain's final shift_out and returns them as readback words, so the previous chain contents can be verified.

Parameters:
- W, 32: config and readback word width in bits.
- CHAIN_LEN, 256: total chain length in bits; must be at least 2.
- NWORDS, ceil(CHAIN_LEN/W): localparam; number of words per load.
- CNT_W, $clog2(CHAIN_LEN+1): localparam; bit counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- start  in  1  begin a load; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until the done cycle, inclusive.
- done  out  1  one-cycle pulse when the load completes.
- cfg_data  in  W  config word; bits are shifted LSB first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  loader accepts cfg_data this cycle.
- rb_data  out  W  readback word; first-returned bit is in the LSB.
- rb_valid  out  1  rb_data valid; held until rb_ready.
- rb_ready  in  1  consumer accepts rb_data.
- chain_cen  out  1  chain shift enable; drives tile cen.
- chain_shift  out  1  serial data; drives the first tile's shift_in.
- chain_set  out  1  config latch pulse; drives tile set_in.
- chain_return  in  1  last tile's shift_out.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, all counters 0. Outputs busy, done, cfg_ready, rb_valid, chain_cen, chain_shift, chain_set are all 0; rb_data is 0.
- FSM states: IDLE -> SHIFT -> FLUSH -> SET -> DONE -> IDLE.
- IDLE: start=1 -> SHIFT. Counters cleared: bits_done=0, words_in=0, collector empty.
- SHIFT, word buffer: a W-bit shift register with a bits_left count.
  - cfg_ready = (words_in < NWORDS) && (bits_left==0 || (bits_left==1 && shift_now)).
  - Accepting a word (cfg_valid && cfg_ready) loads the register and sets bits_left = W.
  - Word reload is therefore bubble-free.
- shift_now = SHIFT && bits_left>0 && bits_done<CHAIN_LEN && !rb_stall.
- chain_cen = shift_now; chain_shift = word_sr[0], valid whenever chain_cen=1.
  - chain_cen has a combinational path from rb_ready. This is permitted.
- On each clk edge with shift_now=1:
  - word_sr shifts right; bits_left decrements; bits_done increments.
  - chain_return is sampled into the collector at bit index (bits_done mod W).
- chain_return is the chain's current last-flop value. The chain updates on the same edge.
- Bits of the final word beyond CHAIN_LEN are never shifted and are discarded. After CHAIN_LEN bits, the remaining bits_left is cleared.
- Readback: a full collector (W bits) transfers to the rb_data/rb_valid register when that register is empty or being drained (rb_ready=1) in the same cycle.
- rb_stall = collector holds W bits && rb_valid && !rb_ready.
  - While stalled, chain_cen=0 and no bit is lost.
  - With rb_ready held low, at most 2W bits are shifted before the stall.
- SHIFT -> FLUSH when bits_done reaches CHAIN_LEN.
- FLUSH: a partial collector (CHAIN_LEN mod W != 0) is zero-padded in its upper bits and pushed out like a full word. FLUSH waits for the rb register to drain, then -> SET.
  - Total readback words = NWORDS.
- SET: chain_set=1 for exactly one cycle; chain_cen=0.
- DONE: done=1 for one cycle -> IDLE. busy falls in the following cycle.
- Outside SHIFT, cfg_valid is ignored and cfg_ready=0.
- start asserted while busy is ignored.
- Reset mid-operation aborts immediately: chain_set is never issued, and the chain keeps the partial shift with no set.

Decomposition:
- Shared package cfg_chain_pkg:
  - FSM state enum (IDLE, SHIFT, FLUSH, SET, DONE).
  - Helper function ceil_div.
- One natural sub-module: cfg_chain_rb_collector. It holds the collector, rb output register, stall and flush-pad logic.
- The top level holds the FSM, word buffer and counters.

Test Plan:
- Use W=4, CHAIN_LEN=10 for all scenarios.
- Reset: hold rst=0 with start=1 and cfg_valid=1 -> busy, cfg_ready, chain_cen, chain_set, rb_valid, done all 0. rst=1 -> remains IDLE until a start pulse.
- Basic load: start, then words 0x5, 0xA, 0xF with cfg_valid held and rb_ready=1 -> chain_cen high 10 contiguous cycles. chain_shift sequence is 1,0,1,0,0,1,0,1,1,1. chain_set pulses once the cycle after FLUSH, then done. 0xF bits 2-3 are never shifted.
- Readback: a second load with words 0x0, 0x0, 0x0 -> rb words 0x5, 0xA, 0x3 in order. The last word keeps only 2 bits, zero-padded.
- Source gaps: cfg_valid low for 3 cycles between words -> chain_cen low during the gaps. Total cen-high cycles still 10; shifted bit order unchanged.
- Readback backpressure: rb_ready=0 from start -> chain_cen high exactly 8 cycles, then stalls with rb_data=first word held. Raising rb_ready -> remaining 2 bits shift, then 3 rb words total, then set and done.
- Reset mid-shift: drop rst after 5 shifts -> all outputs 0 within the reset, no chain_set. A new start performs a full 10-bit load and 3 readback words.

Source files
------------

// File: rtl/cfg_chain_pkg.sv
// rtl/cfg_chain_pkg.sv - shared state encoding and helpers for the config chain loader
package cfg_chain_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      FLUSH,
      SET,
      DONE
   } state_t;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/cfg_chain_rb_collector.sv
// rtl/cfg_chain_rb_collector.sv - gathers chain_return bits into readback words
// and holds them in the rb_data/rb_valid register until the consumer takes them.
module cfg_chain_rb_collector #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         shift_now,
   input  logic         bit_in,
   input  logic         flush,
   output logic         stall,
   output logic         drained,
   output logic [W-1:0] rb_data,
   output logic         rb_valid,
   input  logic         rb_ready
);

   localparam int CW = $clog2(W + 1);
   localparam int IW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(W);

   logic [W-1:0]  col_q;
   logic [W-1:0]  col_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          full;
   logic          xfer;
   logic [IW-1:0] wr_idx;

   assign full    = (cnt_q == FULL_CNT);
   assign stall   = full && rb_valid && !rb_ready;
   assign xfer    = (full || (flush && (cnt_q != '0))) && (!rb_valid || rb_ready);
   assign drained = (cnt_q == '0) && !rb_valid;
   // A full collector always empties on the same edge that a new bit lands.
   assign wr_idx  = full ? '0 : cnt_q[IW-1:0];

   always_comb begin
      col_d = col_q;
      cnt_d = cnt_q;
      if (clear) begin
         col_d = '0;
         cnt_d = '0;
      end else begin
         if (xfer) begin
            col_d = '0;
            cnt_d = '0;
         end
         if (shift_now) begin
            col_d[wr_idx] = bit_in;
            cnt_d         = cnt_d + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q    <= '0;
         cnt_q    <= '0;
         rb_data  <= '0;
         rb_valid <= 1'b0;
      end else begin
         col_q <= col_d;
         cnt_q <= cnt_d;
         // Unfilled upper bits are already zero, which gives the flush padding.
         if (xfer) begin
            rb_data  <= col_q;
            rb_valid <= 1'b1;
         end else if (rb_ready) begin
            rb_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - serializes config words onto a tile shift chain,
// returns the previous chain contents as readback words, then pulses set.
module config_chain_loader
   import cfg_chain_pkg::*;
#(
   parameter int W         = 32,
   parameter int CHAIN_LEN = 256
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         busy,
   output logic         done,
   input  logic [W-1:0] cfg_data,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   output logic [W-1:0] rb_data,
   output logic         rb_valid,
   input  logic         rb_ready,
   output logic         chain_cen,
   output logic         chain_shift,
   output logic         chain_set,
   input  logic         chain_return
);

   localparam int NWORDS = ceil_div(CHAIN_LEN, W);
   localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
   localparam int BL_W   = $clog2(W + 1);
   localparam int WI_W   = $clog2(NWORDS + 1);

   localparam logic [CNT_W-1:0] CHAIN_BITS = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(CHAIN_LEN - 1);
   localparam logic [BL_W-1:0]  WORD_BITS  = BL_W'(W);
   localparam logic [BL_W-1:0]  ONE_BIT    = BL_W'(1);
   localparam logic [WI_W-1:0]  WORD_CNT   = WI_W'(NWORDS);

   state_t            state_q;
   state_t            state_d;
   logic [W-1:0]      word_sr_q;
   logic [BL_W-1:0]   bits_left_q;
   logic [CNT_W-1:0]  bits_done_q;
   logic [WI_W-1:0]   words_in_q;
   logic              shift_now;
   logic              last_bit;
   logic              accept;
   logic              rb_stall;
   logic              col_drained;
   logic              flush;
   logic              clear;

   assign shift_now = (state_q == SHIFT) && (bits_left_q != '0) &&
                      (bits_done_q < CHAIN_BITS) && !rb_stall;
   assign last_bit  = shift_now && (bits_done_q == LAST_BIT);
   // Reload while the last bit of the current word is leaving keeps the chain busy every cycle.
   assign cfg_ready = (state_q == SHIFT) && (words_in_q < WORD_CNT) &&
                      ((bits_left_q == '0) || ((bits_left_q == ONE_BIT) && shift_now));
   assign accept    = cfg_valid && cfg_ready;
   assign clear     = (state_q == IDLE) && start;

   assign chain_cen   = shift_now;
   assign chain_shift = shift_now && word_sr_q[0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      busy      = (state_q != IDLE);
      done      = 1'b0;
      chain_set = 1'b0;
      flush     = 1'b0;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (last_bit) state_d = FLUSH;
         FLUSH: begin
            flush = 1'b1;
            if (col_drained) state_d = SET;
         end
         SET: begin
            chain_set = 1'b1;
            state_d   = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_sr_q   <= '0;
         bits_left_q <= '0;
         bits_done_q <= '0;
         words_in_q  <= '0;
      end else if (state_q == IDLE) begin
         if (start) begin
            bits_left_q <= '0;
            bits_done_q <= '0;
            words_in_q  <= '0;
         end
      end else if (state_q == SHIFT) begin
         if (accept) begin
            word_sr_q   <= cfg_data;
            bits_left_q <= WORD_BITS;
            words_in_q  <= words_in_q + 1'b1;
         end else if (shift_now) begin
            word_sr_q   <= word_sr_q >> 1;
            // Bits of the final word past the chain end are dropped here.
            bits_left_q <= last_bit ? '0 : bits_left_q - 1'b1;
         end
         if (shift_now) begin
            bits_done_q <= bits_done_q + 1'b1;
         end
      end
   end

   cfg_chain_rb_collector #(
      .W (W)
   ) u_rb_collector (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .shift_now (shift_now),
      .bit_in    (chain_return),
      .flush     (flush),
      .stall     (rb_stall),
      .drained   (col_drained),
      .rb_data   (rb_data),
      .rb_valid  (rb_valid),
      .rb_ready  (rb_ready)
   );

endmodule

// File: tb/tb_config_chain_loader.sv
// tb/tb_config_chain_loader.sv - bench for config_chain_loader with a queue model
// of the tile chain and randomized words, gaps and readback backpressure.
module tb_config_chain_loader;

   localparam int W  = 4;
   localparam int CL = 10;
   localparam int NW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          cfg_valid;
   logic          rb_ready;
   logic          chain_return;
   logic [W-1:0]  cfg_data;
   logic [W-1:0]  rb_data;
   logic          busy, done, cfg_ready, rb_valid, chain_cen, chain_shift, chain_set;

   logic [CL-1:0] chain_env = '0;
   logic [CL-1:0] latched   = '0;

   int            tests = 0;
   int            fails = 0;
   bit            chain_q[$];
   bit            got_bits[$];
   logic [W-1:0]  got_rb[$];

   always #5 clk = ~clk;

   config_chain_loader #(.W(W), .CHAIN_LEN(CL)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .cfg_data     (cfg_data),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .rb_data      (rb_data),
      .rb_valid     (rb_valid),
      .rb_ready     (rb_ready),
      .chain_cen    (chain_cen),
      .chain_shift  (chain_shift),
      .chain_set    (chain_set),
      .chain_return (chain_return)
   );

   // Tile row: new bits enter at index 0, the oldest bit sits at the far end.
   assign chain_return = chain_env[CL-1];
   always @(posedge clk) begin
      if (chain_cen) chain_env <= {chain_env[CL-2:0], chain_shift};
      if (chain_set) latched <= chain_env;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_load(input string name, input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input logic [W-1:0] w2, input int gap_len, input int rb_mode,
                           input int abort_after);
      logic [W-1:0]  words [NW];
      logic [W-1:0]  exp_rb [NW];
      bit            exp_bits[$];
      bit            exp_ret[$];
      logic [31:0]   gv, ev;
      logic [CL-1:0] exp_latch;
      int            cen_cnt, cen_first, cen_last, set_cnt, set_cyc, done_cyc;
      int            idx, gap, nshift, cyc;
      bit            fire, got_done, aborted;

      words[0] = w0; words[1] = w1; words[2] = w2;
      exp_bits = {};
      for (int k = 0; k < CL; k++) exp_bits.push_back(words[k / W][k % W]);
      nshift  = (abort_after > 0) ? abort_after : CL;
      exp_ret = {};
      for (int i = 0; i < nshift; i++) begin
         exp_ret.push_back(chain_q.pop_front());
         chain_q.push_back(exp_bits[i]);
      end
      for (int j = 0; j < NW; j++) begin
         exp_rb[j] = '0;
         for (int b = 0; b < W; b++)
            if (j * W + b < nshift) exp_rb[j][b] = exp_ret[j * W + b];
      end
      for (int k = 0; k < CL; k++) exp_latch[CL-1-k] = chain_q[k];

      got_bits = {}; got_rb = {};
      cen_cnt = 0; cen_first = -1; cen_last = -1; set_cnt = 0; set_cyc = -1; done_cyc = -1;
      idx = 0; gap = 0; cyc = 0; got_done = 0; aborted = 0;

      @(posedge clk); #1;
      start     = 1'b1;
      cfg_valid = 1'b1;
      cfg_data  = words[0];
      rb_ready  = (rb_mode == 0) ? 1'b1 : ((rb_mode < 0) ? 1'($urandom_range(0, 1)) : 1'b0);

      while (!got_done && cyc < 300) begin
         @(negedge clk);
         if (chain_cen) begin
            got_bits.push_back(chain_shift);
            cen_cnt++;
            if (cen_first < 0) cen_first = cyc;
            cen_last = cyc;
         end
         if (rb_valid && rb_ready) got_rb.push_back(rb_data);
         if (chain_set) begin set_cnt++; set_cyc = cyc; end
         if (done) begin got_done = 1; done_cyc = cyc; end
         fire = cfg_valid && cfg_ready;
         @(posedge clk); #1;
         cyc++;
         start = (cyc == 3);
         if (fire) begin idx++; gap = gap_len; end
         if (gap > 0) begin cfg_valid = 1'b0; gap--; end
         else if (idx < NW) begin cfg_valid = 1'b1; cfg_data = words[idx]; end
         else cfg_valid = 1'b0;
         if (rb_mode < 0) rb_ready = 1'($urandom_range(0, 1));
         else if (rb_mode > 0) rb_ready = (cyc >= rb_mode);
         if (rb_mode > 0 && cyc == rb_mode - 1) begin
            chk({name, " stall cen count"}, cen_cnt, 2 * W);
            chk({name, " stall cen low"}, chain_cen, 1'b0);
            chk({name, " stall rb_valid"}, rb_valid, 1'b1);
            chk({name, " stall rb_data"}, rb_data, exp_rb[0]);
         end
         if (abort_after > 0 && cen_cnt == abort_after) begin
            aborted = 1;
            break;
         end
      end

      if (aborted) begin
         rst = 1'b0;
         #1;
         chk({name, " abort busy"}, busy, 1'b0);
         chk({name, " abort cfg_ready"}, cfg_ready, 1'b0);
         chk({name, " abort cen"}, chain_cen, 1'b0);
         chk({name, " abort rb_valid"}, rb_valid, 1'b0);
         chk({name, " abort rb_data"}, rb_data, '0);
         start = 1'b0; cfg_valid = 1'b0;
         repeat (3) begin
            @(negedge clk);
            if (chain_set) set_cnt++;
         end
         @(posedge clk); #1;
         rst = 1'b1;
         chk({name, " abort no set"}, set_cnt, 0);
         gv = '0; ev = '0;
         foreach (got_bits[i]) gv[i] = got_bits[i];
         for (int i = 0; i < abort_after; i++) ev[i] = exp_bits[i];
         chk({name, " abort shifted bits"}, gv, ev);
         return;
      end

      start = 1'b0; cfg_valid = 1'b0; rb_ready = 1'b1;
      chk({name, " completed"}, got_done, 1'b1);
      chk({name, " cen count"}, cen_cnt, CL);
      gv = '0; ev = '0;
      foreach (got_bits[i]) gv[i] = got_bits[i];
      for (int i = 0; i < CL; i++) ev[i] = exp_bits[i];
      chk({name, " shifted bits"}, gv, ev);
      chk({name, " set count"}, set_cnt, 1);
      chk({name, " done after set"}, done_cyc, set_cyc + 1);
      chk({name, " rb word count"}, got_rb.size(), NW);
      for (int j = 0; j < NW && j < got_rb.size(); j++)
         chk($sformatf("%s rb word %0d", name, j), got_rb[j], exp_rb[j]);
      chk({name, " latched config"}, latched, exp_latch);
      if (rb_mode == 0 && gap_len == 0)
         chk({name, " cen contiguous"}, cen_last - cen_first + 1, CL);
      if (rb_mode == 0 && gap_len >= W)
         chk({name, " cen span with gaps"}, cen_last - cen_first + 1,
             CL + (NW - 1) * (gap_len - W + 1));
      @(negedge clk);
      chk({name, " busy cleared"}, busy, 1'b0);
   endtask

   initial begin
      logic [W-1:0] a, b, c;
      rst = 1'b0; start = 1'b1; cfg_valid = 1'b1; cfg_data = '1; rb_ready = 1'b1;
      for (int i = 0; i < CL; i++) chain_q.push_back(1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", busy, 1'b0);
      chk("reset cfg_ready", cfg_ready, 1'b0);
      chk("reset chain_cen", chain_cen, 1'b0);
      chk("reset chain_shift", chain_shift, 1'b0);
      chk("reset chain_set", chain_set, 1'b0);
      chk("reset rb_valid", rb_valid, 1'b0);
      chk("reset rb_data", rb_data, '0);
      chk("reset done", done, 1'b0);
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle busy", busy, 1'b0);
      chk("idle cfg_ready", cfg_ready, 1'b0);
      cfg_valid = 1'b0;

      run_load("basic", 4'h5, 4'hA, 4'hF, 0, 0, 0);
      a = 4'h0;
      for (int i = 0; i < CL; i++) a = a;
      begin
         logic [31:0] gv;
         gv = '0;
         foreach (got_bits[i]) gv[i] = got_bits[i];
         chk("basic spec bit sequence", gv, 32'h3A5);
      end

      run_load("readback", 4'h0, 4'h0, 4'h0, 0, 0, 0);
      chk("readback spec count", got_rb.size(), NW);
      if (got_rb.size() == NW) begin
         chk("readback spec word0", got_rb[0], 4'h5);
         chk("readback spec word1", got_rb[1], 4'hA);
         chk("readback spec word2", got_rb[2], 4'h3);
      end

      a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); c = 4'($urandom_range(0, 15));
      run_load("gaps", a, b, c, W + int'($urandom_range(1, 3)), 0, 0);

      a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); c = 4'($urandom_range(0, 15));
      run_load("backpressure", a, b, c, 0, 20, 0);

      a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); c = 4'($urandom_range(0, 15));
      run_load("abort", a, b, c, 0, 0, 5);

      a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); c = 4'($urandom_range(0, 15));
      run_load("after abort", a, b, c, 0, 0, 0);

      for (int n = 0; n < 3; n++) begin
         a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); c = 4'($urandom_range(0, 15));
         run_load($sformatf("random%0d", n), a, b, c, int'($urandom_range(0, 6)), -1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
